load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Parametrised successor to the WB-stage load data extractor: accepts a load request, issues one or two aligned memory beats, merges them, and returns the size-extracted, sign- or zero-extended result.
- Handles loads that cross a bus-word boundary by splitting them into two beats. Sits between the MEM-stage load request and the data-memory port; the result feeds WB.
- Processes one load at a time; all handshakes are valid/ready.

Parameters:
- XLEN, 32, data/bus width in bits; legal values 32 or 64. BYTES = XLEN/8, OFFW = log2(BYTES).
- ALLOW_MISALIGN, 1, 1 = split boundary-crossing loads into two beats; 0 = flag them as errors with no memory access.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_addr  in  32  byte address
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only when XLEN=64)
- req_sign  in  1  1=sign-extend, 0=zero-extend
- mem_req_valid  out  1  memory beat request valid
- mem_req_ready  in  1  memory accepts the beat
- mem_req_addr  out  32  beat address; low OFFW bits are always 0
- mem_rsp_valid  in  1  memory read data valid (one per accepted beat, in order)
- mem_rsp_data  in  XLEN  memory read data
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts the result
- rsp_data  out  XLEN  extended result
- rsp_err  out  1  illegal size or disallowed misalignment; rsp_data=0 when set

Behaviour:
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Reset (async, rst_n=0): state=IDLE; mem_req_valid=0, rsp_valid=0, rsp_err=0, rsp_data=0, mem_req_addr=0; all captured registers cleared. Reset asserted mid-transaction abandons it; a memory response arriving after reset release while in IDLE is ignored.
- IDLE:
  - req_ready=1. On req_valid, capture addr, size, sign; off = addr[OFFW-1:0], nbytes = 1<<size.
  - size=3 with XLEN=32 -> RESP with err.
  - Crossing (off+nbytes > BYTES) with ALLOW_MISALIGN=0 -> RESP with err.
  - Otherwise -> REQ0.
- REQ0: mem_req_valid=1, mem_req_addr = addr with low OFFW bits cleared; hold until mem_req_ready, then -> WAIT0.
- WAIT0: on mem_rsp_valid, capture beat0. If crossing -> REQ1, else -> RESP.
- REQ1: mem_req_addr = aligned addr + BYTES, wrapping modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000); on mem_req_ready -> WAIT1.
- WAIT1: on mem_rsp_valid, capture beat1 -> RESP.
- Merge: form {beat1, beat0} (2*XLEN bits; beat1=0 if single-beat), shift right by off*8, keep the low nbytes*8 bits, extend to XLEN per sign. Size equal to XLEN is passed unextended.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are registered and stable until rsp_ready.
  - On rsp_ready -> IDLE; rsp_valid drops the next cycle.
  - No new request is accepted in the same cycle as the response handshake (req_ready is low in RESP).
- Latency, with zero-wait memory (ready and rsp one cycle after request):
  - single-beat: req accept -> rsp_valid in 3 cycles;
  - split: 5 cycles;
  - error: 1 cycle.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored. mem_req_valid is never deasserted before mem_req_ready.

Decomposition:
- Shared package (pipeline mem pkg): size encodings SZ_B/SZ_H/SZ_W/SZ_D, state enum, BYTES/OFFW derivation function.
- One natural sub-module, load_extract: combinational merge/shift/extend of {beat1, beat0} by off, size and sign. It is the generalised form of the existing byte/half extender and is reusable for the store-side mask check.
- The FSM, address generation and handshakes stay in the top module.

Test Plan:
- XLEN=32, addr=0x1003, size=0, sign=1, memory word 0x80FF_1234 -> one beat at 0x1000; rsp_data=0xFFFFFF80, err=0; rsp_valid 3 cycles after accept.
- XLEN=32, addr=0x1002, size=1, sign=0, word 0xBEEF_0000 -> rsp_data=0x0000BEEF, single beat.
- XLEN=32, ALLOW_MISALIGN=1, addr=0x1003, size=2, beats 0xAA000000 @0x1000 and 0x00CCBBDD @0x1004 -> beats issued to 0x1000 then 0x1004; rsp_data=0xCCBBDDAA; rsp_valid 5 cycles after accept.
- XLEN=32, addr=0xFFFFFFFE, size=2 -> second beat addr wraps to 0x00000000. With ALLOW_MISALIGN=0, same request -> no mem_req_valid, rsp_err=1, rsp_data=0.
- XLEN=64, addr=0x2004, size=2, sign=1, dword 0x8765_4321_0000_0000 -> rsp_data=0xFFFFFFFF87654321. XLEN=32 with size=3 -> rsp_err=1.
- Backpressure/reset:
  - mem_req_ready held low 4 cycles -> mem_req_valid and mem_req_addr stable throughout.
  - rsp_ready low 3 cycles -> rsp_data stable and req_ready=0.
  - rst_n pulsed low in WAIT0 -> all outputs 0 immediately; a late mem_rsp_valid is ignored.

Source files
------------

// File: rtl/load_align_pkg.sv
// Shared definitions for the load alignment unit:
// size encodings, FSM state type and bus geometry helpers.
package load_align_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } state_t;

    function automatic int bytes_of(input int xlen);
        return xlen / 8;
    endfunction

    function automatic int offw_of(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Merge/shift/extend of a two-beat window into a load result.
// Ports: pair={beat1,beat0}, off=byte offset, size, sign -> data.
module load_extract
    import load_align_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = offw_of(XLEN)
) (
    input  logic [2*XLEN-1:0] pair,
    input  logic [OFFW-1:0]   off,
    input  logic [1:0]        size,
    input  logic              sign,
    output logic [XLEN-1:0]   data
);

    logic [XLEN-1:0] low;
    logic [XLEN-1:0] mask;
    logic            msb;

    // Only the low XLEN bits of the shifted window can hold the datum.
    assign low = XLEN'(pair >> {off, 3'b000});

    always_comb begin
        mask = '1;
        msb  = 1'b0;
        case (size)
            SZ_B: begin
                mask = XLEN'(8'hFF);
                msb  = low[7];
            end
            SZ_H: begin
                mask = XLEN'(16'hFFFF);
                msb  = low[15];
            end
            SZ_W: begin
                mask = XLEN'(32'hFFFF_FFFF);
                msb  = low[31];
            end
            default: begin
                mask = '1;
                msb  = 1'b0;
            end
        endcase
        // A full-width load has mask all ones, so it is never extended.
        data = (low & mask) | ((sign && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: issues one or two aligned memory beats per load,
// merges them and returns the size-extracted, extended result.
// Ports: req_* load request in, mem_req_*/mem_rsp_* memory port,
// rsp_* result out (rsp_err flags illegal size / disallowed misalignment).
module load_align_unit
    import load_align_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_sign,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [31:0]     mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err
);

    localparam int BYTES = bytes_of(XLEN);
    localparam int OFFW  = offw_of(XLEN);

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     addr_q;
    logic [1:0]      size_q;
    logic            sign_q;
    logic            cross_q;
    logic [XLEN-1:0] beat0_q;
    logic [XLEN-1:0] rsp_data_q;
    logic            rsp_err_q;

    logic [4:0]      span;
    logic            cross_in;
    logic            bad_size;
    logic            req_bad;
    logic [31:0]     aligned;
    logic [2*XLEN-1:0] pair;
    logic [XLEN-1:0] ext;

    assign span     = 5'(req_addr[OFFW-1:0]) + (5'd1 << req_size);
    assign cross_in = span > 5'(BYTES);
    assign bad_size = (req_size == SZ_D) && (XLEN < 64);
    assign req_bad  = bad_size || (cross_in && !ALLOW_MISALIGN);
    assign aligned  = {addr_q[31:OFFW], {OFFW{1'b0}}};

    // The final beat is merged straight off the bus so the result
    // register loads on the same edge the data arrives.
    assign pair = (state == WAIT1) ? {mem_rsp_data, beat0_q}
                                   : {{XLEN{1'b0}}, mem_rsp_data};

    load_extract #(
        .XLEN (XLEN),
        .OFFW (OFFW)
    ) u_extract (
        .pair (pair),
        .off  (addr_q[OFFW-1:0]),
        .size (size_q),
        .sign (sign_q),
        .data (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        rsp_valid     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_bad ? RESP : REQ0;
            end
            REQ0: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = aligned;
                if (mem_req_ready) state_nxt = WAIT0;
            end
            WAIT0: begin
                if (mem_rsp_valid) state_nxt = cross_q ? REQ1 : RESP;
            end
            REQ1: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = aligned + 32'(BYTES);
                if (mem_req_ready) state_nxt = WAIT1;
            end
            WAIT1: begin
                if (mem_rsp_valid) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            cross_q    <= 1'b0;
            beat0_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        size_q     <= req_size;
                        sign_q     <= req_sign;
                        cross_q    <= cross_in;
                        rsp_data_q <= '0;
                        rsp_err_q  <= req_bad;
                    end
                end
                WAIT0: begin
                    if (mem_rsp_valid) begin
                        beat0_q <= mem_rsp_data;
                        if (!cross_q) rsp_data_q <= ext;
                    end
                end
                WAIT1: begin
                    if (mem_rsp_valid) rsp_data_q <= ext;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: three instances
// (32-bit split, 32-bit no-misalign, 64-bit split) behind one driver.
module tb_load_align_unit;
    import load_align_pkg::*;

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign;
        logic [63:0] w0;
        logic [63:0] w1;
        logic [63:0] data;
        logic        err;
        int          lat;
        int          beats;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid_a [3];
    logic [31:0] req_addr_a  [3];
    logic [1:0]  req_size_a  [3];
    logic        req_sign_a  [3];
    logic        mready_a    [3];
    logic        mrv_a       [3];
    logic        rsp_ready_a [3];
    logic [31:0] mrd32       [2];
    logic [63:0] mrd64;
    logic        inj_v;

    logic        rr_o [3];
    logic        mv_o [3];
    logic [31:0] ma_o [3];
    logic        rv_o [3];
    logic        re_o [3];
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [63:0] rd2;
    logic [63:0] rd_o [3];

    assign rd_o[0] = {32'b0, rd0};
    assign rd_o[1] = {32'b0, rd1};
    assign rd_o[2] = rd2;

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGN(1'b1)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid_a[0]),
        .req_ready     (rr_o[0]),
        .req_addr      (req_addr_a[0]),
        .req_size      (req_size_a[0]),
        .req_sign      (req_sign_a[0]),
        .mem_req_valid (mv_o[0]),
        .mem_req_ready (mready_a[0]),
        .mem_req_addr  (ma_o[0]),
        .mem_rsp_valid (mrv_a[0] | inj_v),
        .mem_rsp_data  (mrd32[0]),
        .rsp_valid     (rv_o[0]),
        .rsp_ready     (rsp_ready_a[0]),
        .rsp_data      (rd0),
        .rsp_err       (re_o[0])
    );

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGN(1'b0)) u_nomis (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid_a[1]),
        .req_ready     (rr_o[1]),
        .req_addr      (req_addr_a[1]),
        .req_size      (req_size_a[1]),
        .req_sign      (req_sign_a[1]),
        .mem_req_valid (mv_o[1]),
        .mem_req_ready (mready_a[1]),
        .mem_req_addr  (ma_o[1]),
        .mem_rsp_valid (mrv_a[1]),
        .mem_rsp_data  (mrd32[1]),
        .rsp_valid     (rv_o[1]),
        .rsp_ready     (rsp_ready_a[1]),
        .rsp_data      (rd1),
        .rsp_err       (re_o[1])
    );

    load_align_unit #(.XLEN(64), .ALLOW_MISALIGN(1'b1)) u_x64 (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid_a[2]),
        .req_ready     (rr_o[2]),
        .req_addr      (req_addr_a[2]),
        .req_size      (req_size_a[2]),
        .req_sign      (req_sign_a[2]),
        .mem_req_valid (mv_o[2]),
        .mem_req_ready (mready_a[2]),
        .mem_req_addr  (ma_o[2]),
        .mem_rsp_valid (mrv_a[2]),
        .mem_rsp_data  (mrd64),
        .rsp_valid     (rv_o[2]),
        .rsp_ready     (rsp_ready_a[2]),
        .rsp_data      (rd2),
        .rsp_err       (re_o[2])
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem32 [logic [31:0]];
    logic [63:0] mem64 [logic [31:0]];
    logic [31:0] beat_q [$];
    exp_t        sb [$];
    bit          auto_rsp = 1'b1;
    bit          pend [3];
    logic [31:0] pend_addr [3];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model: checks each accepted beat address against the
    // expected order and answers one cycle later.
    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 3; i++) begin
            mrv_a[i] = 1'b0;
            if (pend[i]) begin
                mrv_a[i] = 1'b1;
                if (i == 2) mrd64 = mem64[pend_addr[i]];
                else        mrd32[i] = mem32[pend_addr[i]];
                pend[i] = 1'b0;
            end
            if (mv_o[i] && mready_a[i]) begin
                if (beat_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected beat: got %h expected none",
                             ma_o[i]);
                end else begin
                    chk("beat addr", 64'(ma_o[i]),
                        64'(beat_q.pop_front()));
                end
                pend[i]      = auto_rsp;
                pend_addr[i] = ma_o[i];
            end
        end
    end

    task automatic do_load(input vec_t v, input int mr_hold,
                           input int rr_hold);
        int          i;
        int          hold;
        int          lat;
        bit          got;
        logic [31:0] al;
        logic [31:0] nx;
        logic [63:0] d;
        logic        e;
        exp_t        x;
        i    = v.inst;
        hold = mr_hold;
        al   = (i == 2) ? (v.addr & 32'hFFFF_FFF8) : (v.addr & 32'hFFFF_FFFC);
        nx   = al + ((i == 2) ? 32'd8 : 32'd4);
        if (i == 2) begin
            mem64[al] = v.w0;
            mem64[nx] = v.w1;
        end else begin
            mem32[al] = v.w0[31:0];
            mem32[nx] = v.w1[31:0];
        end
        if (v.beats > 0) beat_q.push_back(al);
        if (v.beats > 1) beat_q.push_back(nx);
        sb.push_back('{v.data, v.err, v.lat});
        @(negedge clk);
        mready_a[i]    = (mr_hold == 0);
        req_addr_a[i]  = v.addr;
        req_size_a[i]  = v.size;
        req_sign_a[i]  = v.sign;
        req_valid_a[i] = 1'b1;
        chk("req_ready idle", 64'(rr_o[i]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid_a[i] = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (hold > 0) begin
                chk("mreq held valid", 64'(mv_o[i]), 64'd1);
                chk("mreq held addr", 64'(ma_o[i]), 64'(al));
                hold--;
                if (hold == 0) mready_a[i] = 1'b1;
            end
            if (rv_o[i]) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL rsp timeout: got none expected rsp_valid");
            beat_q.delete();
            void'(sb.pop_front());
            mready_a[i] = 1'b1;
            return;
        end
        d = rd_o[i];
        e = re_o[i];
        for (int k = 0; k < rr_hold; k++) begin
            chk("rsp stall data", rd_o[i], d);
            chk("rsp stall valid", 64'(rv_o[i]), 64'd1);
            chk("rsp stall req_ready", 64'(rr_o[i]), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready_a[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_a[i] = 1'b0;
        x = sb.pop_front();
        chk("rsp_data", d, x.data);
        chk("rsp_err", 64'(e), 64'(x.err));
        if (x.lat > 0) chk("latency", 64'(lat), 64'(x.lat));
        chk("rsp_valid drop", 64'(rv_o[i]), 64'd0);
        chk("beats issued", 64'(beat_q.size()), 64'd0);
    endtask

    vec_t vt [17];
    vec_t hv;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid_a[i] = 1'b0;
            req_addr_a[i]  = '0;
            req_size_a[i]  = '0;
            req_sign_a[i]  = 1'b0;
            mready_a[i]    = 1'b1;
            mrv_a[i]       = 1'b0;
            rsp_ready_a[i] = 1'b0;
            pend[i]        = 1'b0;
            pend_addr[i]   = '0;
        end
        mrd32[0] = '0;
        mrd32[1] = '0;
        mrd64    = '0;
        inj_v    = 1'b0;

        vt[0]  = '{0, 32'h1003, SZ_B, 1'b1, 64'h80FF1234, 64'h0,
                   64'hFFFFFF80, 1'b0, 3, 1};
        vt[1]  = '{0, 32'h1002, SZ_H, 1'b0, 64'hBEEF0000, 64'h0,
                   64'h0000BEEF, 1'b0, 3, 1};
        vt[2]  = '{0, 32'h1003, SZ_W, 1'b0, 64'hAA000000, 64'h00CCBBDD,
                   64'hCCBBDDAA, 1'b0, 5, 2};
        vt[3]  = '{0, 32'hFFFFFFFE, SZ_W, 1'b0, 64'h55667788, 64'h11223344,
                   64'h33445566, 1'b0, 5, 2};
        vt[4]  = '{1, 32'hFFFFFFFE, SZ_W, 1'b0, 64'h0, 64'h0,
                   64'h0, 1'b1, 1, 0};
        vt[5]  = '{2, 32'h2004, SZ_W, 1'b1, 64'h8765432100000000, 64'h0,
                   64'hFFFFFFFF87654321, 1'b0, 3, 1};
        vt[6]  = '{0, 32'h1000, SZ_D, 1'b0, 64'h0, 64'h0,
                   64'h0, 1'b1, 1, 0};
        vt[7]  = '{0, 32'h1001, SZ_H, 1'b1, 64'h00800100, 64'h0,
                   64'hFFFF8001, 1'b0, 3, 1};
        vt[8]  = '{0, 32'h1002, SZ_W, 1'b1, 64'h12345678, 64'h9ABCDEF0,
                   64'hDEF01234, 1'b0, 5, 2};
        vt[9]  = '{1, 32'h2000, SZ_W, 1'b0, 64'hCAFEF00D, 64'h0,
                   64'hCAFEF00D, 1'b0, 3, 1};
        vt[10] = '{1, 32'h2003, SZ_H, 1'b0, 64'h0, 64'h0,
                   64'h0, 1'b1, 1, 0};
        vt[11] = '{2, 32'h2007, SZ_H, 1'b0, 64'hAB00000000000000,
                   64'h00000000000000CD, 64'h000000000000CDAB, 1'b0, 5, 2};
        vt[12] = '{2, 32'h3000, SZ_D, 1'b1, 64'hFEDCBA9876543210, 64'h0,
                   64'hFEDCBA9876543210, 1'b0, 3, 1};
        vt[13] = '{2, 32'h3004, SZ_D, 1'b0, 64'h7654321000000000,
                   64'h00000000FEDCBA98, 64'hFEDCBA9876543210, 1'b0, 5, 2};
        vt[14] = '{0, 32'h1000, SZ_B, 1'b0, 64'h000000F0, 64'h0,
                   64'h000000F0, 1'b0, 3, 1};
        vt[15] = '{2, 32'h3001, SZ_B, 1'b1, 64'h000000000000FF00, 64'h0,
                   64'hFFFFFFFFFFFFFFFF, 1'b0, 3, 1};
        vt[16] = '{2, 32'h3006, SZ_W, 1'b0, 64'hBBAA000000000000,
                   64'h000000000000DDCC, 64'h00000000DDCCBBAA, 1'b0, 5, 2};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset mreq valid", 64'(mv_o[i]), 64'd0);
            chk("reset mreq addr", 64'(ma_o[i]), 64'd0);
            chk("reset rsp valid", 64'(rv_o[i]), 64'd0);
            chk("reset rsp data", rd_o[i], 64'd0);
            chk("reset rsp err", 64'(re_o[i]), 64'd0);
        end

        for (int n = 0; n < 17; n++) do_load(vt[n], 0, 0);

        hv = '{0, 32'h1004, SZ_W, 1'b0, 64'h0BADBEEF, 64'h0,
               64'h0BADBEEF, 1'b0, 0, 1};
        do_load(hv, 4, 0);
        do_load(vt[2], 0, 3);

        // Reset while waiting for the first beat, then a stray response.
        auto_rsp = 1'b0;
        mem32[32'h1000] = 32'h11111111;
        beat_q.push_back(32'h1000);
        @(negedge clk);
        req_addr_a[0]  = 32'h1000;
        req_size_a[0]  = SZ_W;
        req_sign_a[0]  = 1'b0;
        req_valid_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_a[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("wait0 mreq valid", 64'(mv_o[0]), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst mreq valid", 64'(mv_o[0]), 64'd0);
        chk("async rst mreq addr", 64'(ma_o[0]), 64'd0);
        chk("async rst rsp valid", 64'(rv_o[0]), 64'd0);
        chk("async rst rsp data", rd_o[0], 64'd0);
        chk("async rst rsp err", 64'(re_o[0]), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        auto_rsp = 1'b1;
        inj_v    = 1'b1;
        @(negedge clk);
        inj_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stray rsp valid", 64'(rv_o[0]), 64'd0);
            chk("stray mreq valid", 64'(mv_o[0]), 64'd0);
            chk("stray req_ready", 64'(rr_o[0]), 64'd1);
            @(negedge clk);
        end
        chk("beats after reset", 64'(beat_q.size()), 64'd0);
        do_load(vt[0], 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
